// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the state type of the merged read/write master.
package axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } axi_size_e;

  localparam logic [2:0] PROT_INSTR = 3'b100;
  localparam logic [2:0] PROT_DATA  = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B
  } state_e;

endpackage

// File: rtl/axi_rw_arb.sv
// Fixed-priority (load/store over fetch) request select with the capture
// register that holds the granted request for the rest of the transaction.
module axi_rw_arb
  import axi_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                grant_en_i,
  input  logic                if_valid_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                ls_valid_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [2:0]          ls_size_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wstrb_i,
  output logic                if_ready_o,
  output logic                ls_ready_o,
  output logic                req_ls_o,
  output logic [ADDR_W-1:0]   req_addr_o,
  output logic [2:0]          req_size_o,
  output logic [DATA_W-1:0]   req_wdata_o,
  output logic [DATA_W/8-1:0] req_wstrb_o
);

  logic                reqLs_q, reqLs_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;

  assign ls_ready_o = grant_en_i & ls_valid_i;
  assign if_ready_o = grant_en_i & if_valid_i & ~ls_valid_i;

  always_comb begin
    reqLs_d = reqLs_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if (ls_ready_o) begin
      reqLs_d = 1'b1;
      addr_d  = ls_addr_i;
      size_d  = ls_size_i;
      wdata_d = ls_wdata_i;
      wstrb_d = ls_wstrb_i;
    end else if (if_ready_o) begin
      reqLs_d = 1'b0;
      addr_d  = if_addr_i;
      size_d  = SIZE_4B;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      reqLs_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      reqLs_q <= reqLs_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign req_ls_o    = reqLs_q;
  assign req_addr_o  = addr_q;
  assign req_size_o  = size_q;
  assign req_wdata_o = wdata_q;
  assign req_wstrb_o = wstrb_q;

endmodule

// File: rtl/axi_rw_master.sv
// Single-outstanding AXI4 master merging the fetch port and the load/store
// port onto one bus; the FSM and all channel drivers live here.
module axi_rw_master
  import axi_pkg::*;
#(
  parameter int          ADDR_W = 64,
  parameter int          DATA_W = 64,
  parameter int          ID_W   = 4,
  parameter int unsigned IF_ID  = 0,
  parameter int unsigned LS_ID  = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [31:0]         if_rdata,
  output logic                if_rvalid,
  output logic                if_err,
  input  logic                ls_valid,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [2:0]          ls_size,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_ready,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_rvalid,
  output logic                ls_err,
  output logic [ID_W-1:0]     ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [7:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic [2:0]          ARPROT,
  output logic                ARLOCK,
  output logic [3:0]          ARCACHE,
  output logic [3:0]          ARQOS,
  output logic [3:0]          ARREGION,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [ID_W-1:0]     RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [7:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic [2:0]          AWPROT,
  output logic                AWLOCK,
  output logic [3:0]          AWCACHE,
  output logic [3:0]          AWQOS,
  output logic [3:0]          AWREGION,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  state_e              state_q, state_d;
  logic                awDone_q, awDone_d, wDone_q, wDone_d;
  logic                ifRvalid_q, ifRvalid_d, ifErr_q, ifErr_d;
  logic                lsRvalid_q, lsRvalid_d, lsErr_q, lsErr_d;
  logic [31:0]         ifRdata_q, ifRdata_d;
  logic [DATA_W-1:0]   lsRdata_q, lsRdata_d;
  logic                grantEn, reqLs, rdErr;
  logic [ADDR_W-1:0]   reqAddr;
  logic [2:0]          reqSize;
  logic [DATA_W-1:0]   reqWdata;
  logic [DATA_W/8-1:0] reqWstrb;
  logic [ID_W-1:0]     expId;
  logic [31:0]         fetchWord;

  // No grant during the response-pulse cycle, so a requester sees its
  // completion before it can be accepted again (4 cycles per read minimum).
  assign grantEn = rstn & (state_q == ST_IDLE) & ~ifRvalid_q & ~lsRvalid_q;

  axi_rw_arb #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_arb (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .grant_en_i  (grantEn),
    .if_valid_i  (if_valid),
    .if_addr_i   (if_addr),
    .ls_valid_i  (ls_valid),
    .ls_addr_i   (ls_addr),
    .ls_size_i   (ls_size),
    .ls_wdata_i  (ls_wdata),
    .ls_wstrb_i  (ls_wstrb),
    .if_ready_o  (if_ready),
    .ls_ready_o  (ls_ready),
    .req_ls_o    (reqLs),
    .req_addr_o  (reqAddr),
    .req_size_o  (reqSize),
    .req_wdata_o (reqWdata),
    .req_wstrb_o (reqWstrb)
  );

  assign expId = reqLs ? ID_W'(LS_ID) : ID_W'(IF_ID);
  assign rdErr = (RRESP != RESP_OKAY) | (RID != expId) | ~RLAST;

  generate
    if (DATA_W == 64) begin : g_fetch64
      assign fetchWord = reqAddr[2] ? RDATA[63:32] : RDATA[31:0];
    end else begin : g_fetch32
      assign fetchWord = RDATA[31:0];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    awDone_d   = awDone_q;
    wDone_d    = wDone_q;
    ifRvalid_d = 1'b0;
    ifErr_d    = 1'b0;
    lsRvalid_d = 1'b0;
    lsErr_d    = 1'b0;
    ifRdata_d  = ifRdata_q;
    lsRdata_d  = lsRdata_q;
    unique case (state_q)
      ST_IDLE: begin
        awDone_d = 1'b0;
        wDone_d  = 1'b0;
        if (ls_ready)      state_d = ls_we ? ST_AW_W : ST_AR;
        else if (if_ready) state_d = ST_AR;
      end
      ST_AR: if (ARREADY) state_d = ST_R;
      ST_R: begin
        if (RVALID) begin
          state_d = ST_IDLE;
          if (reqLs) begin
            lsRvalid_d = 1'b1;
            lsErr_d    = rdErr;
            lsRdata_d  = RDATA;
          end else begin
            ifRvalid_d = 1'b1;
            ifErr_d    = rdErr;
            ifRdata_d  = fetchWord;
          end
        end
      end
      ST_AW_W: begin
        awDone_d = awDone_q | AWREADY;
        wDone_d  = wDone_q | WREADY;
        if (awDone_d && wDone_d) state_d = ST_B;
      end
      ST_B: begin
        if (BVALID) begin
          state_d    = ST_IDLE;
          lsRvalid_d = 1'b1;
          lsErr_d    = (BRESP != RESP_OKAY) | (BID != ID_W'(LS_ID));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      awDone_q   <= 1'b0;
      wDone_q    <= 1'b0;
      ifRvalid_q <= 1'b0;
      ifErr_q    <= 1'b0;
      lsRvalid_q <= 1'b0;
      lsErr_q    <= 1'b0;
      ifRdata_q  <= '0;
      lsRdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      awDone_q   <= awDone_d;
      wDone_q    <= wDone_d;
      ifRvalid_q <= ifRvalid_d;
      ifErr_q    <= ifErr_d;
      lsRvalid_q <= lsRvalid_d;
      lsErr_q    <= lsErr_d;
      ifRdata_q  <= ifRdata_d;
      lsRdata_q  <= lsRdata_d;
    end
  end

  assign if_rvalid = ifRvalid_q;
  assign if_err    = ifErr_q;
  assign if_rdata  = ifRdata_q;
  assign ls_rvalid = lsRvalid_q;
  assign ls_err    = lsErr_q;
  assign ls_rdata  = lsRdata_q;

  assign ARVALID  = (state_q == ST_AR);
  assign ARID     = expId;
  assign ARADDR   = reqAddr;
  assign ARSIZE   = reqSize;
  assign ARPROT   = reqLs ? PROT_DATA : PROT_INSTR;
  assign ARLEN    = 8'd0;
  assign ARBURST  = BURST_INCR;
  assign ARLOCK   = 1'b0;
  assign ARCACHE  = 4'd0;
  assign ARQOS    = 4'd0;
  assign ARREGION = 4'd0;
  assign RREADY   = (state_q == ST_R);

  assign AWVALID  = (state_q == ST_AW_W) & ~awDone_q;
  assign AWID     = ID_W'(LS_ID);
  assign AWADDR   = reqAddr;
  assign AWSIZE   = reqSize;
  assign AWPROT   = PROT_DATA;
  assign AWLEN    = 8'd0;
  assign AWBURST  = BURST_INCR;
  assign AWLOCK   = 1'b0;
  assign AWCACHE  = 4'd0;
  assign AWQOS    = 4'd0;
  assign AWREGION = 4'd0;
  assign WVALID   = (state_q == ST_AW_W) & ~wDone_q;
  assign WDATA    = reqWdata;
  assign WSTRB    = reqWstrb;
  assign WLAST    = 1'b1;
  assign BREADY   = (state_q == ST_B);

endmodule

// File: tb/tb_axi_rw_master.sv
// Scoreboarded bench for axi_rw_master: a reactive AXI slave checks request
// fields, a monitor checks completions against a behavioural model.
module tb_axi_rw_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        if_valid = 1'b0, ls_valid = 1'b0, ls_we = 1'b0;
  logic [63:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic [2:0]  ls_size = '0;
  logic [7:0]  ls_wstrb = '0;
  logic        if_ready, if_rvalid, if_err, ls_ready, ls_rvalid, ls_err;
  logic [31:0] if_rdata;
  logic [63:0] ls_rdata;
  logic [3:0]  ARID, AWID, RID, BID;
  logic [63:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [7:0]  ARLEN, AWLEN, WSTRB;
  logic [2:0]  ARSIZE, ARPROT, AWSIZE, AWPROT;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARLOCK, AWLOCK, ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [3:0]  ARCACHE, ARQOS, ARREGION, AWCACHE, AWQOS, AWREGION;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  always #5 clk = ~clk;

  axi_rw_master dut (
    .clk(clk), .rstn(rstn),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_rvalid(if_rvalid), .if_err(if_err),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .ls_rvalid(ls_rvalid), .ls_err(ls_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARPROT(ARPROT), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARQOS(ARQOS), .ARREGION(ARREGION),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWPROT(AWPROT), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWQOS(AWQOS), .AWREGION(AWREGION),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  typedef struct {
    bit          write;
    bit          isIf;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          arDelay;
    int          awDelay;
    int          wDelay;
    logic [63:0] rdata;
    logic [1:0]  resp;
    logic [3:0]  rid;
    bit          rlast;
  } txn_t;

  typedef struct {
    bit          isIf;
    logic [63:0] data;
    bit          err;
  } exp_t;

  txn_t        reqQ[$];
  exp_t        expQ[$];
  int          assertCount = 0;
  int          failCount = 0;
  logic [63:0] lastLsData = '0;
  bit          manualSlave = 1'b0;
  bit          tputMode = 1'b0;
  int          cyc = 0;
  int          lastIfCyc = -1;
  int          tputSeen = 0;
  txn_t        st;
  exp_t        me;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: completion contents follow directly from the AXI response rules.
  task automatic predict(input txn_t t);
    exp_t e;
    e.isIf = t.isIf;
    if (t.write) begin
      e.data = lastLsData;
      e.err  = (t.resp != 2'b00) || (t.rid != 4'd1);
    end else if (t.isIf) begin
      e.data = {32'h0, (t.addr[2] ? t.rdata[63:32] : t.rdata[31:0])};
      e.err  = (t.resp != 2'b00) || (t.rid != 4'd0) || !t.rlast;
    end else begin
      e.data     = t.rdata;
      lastLsData = t.rdata;
      e.err      = (t.resp != 2'b00) || (t.rid != 4'd1) || !t.rlast;
    end
    expQ.push_back(e);
  endtask

  task automatic waitGrant(input bit isIf);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      #1;
      if (isIf ? if_ready : ls_ready) begin
        got = 1'b1;
        checkOutput("exclusive grant", isIf ? ls_ready : if_ready, 0);
      end else @(negedge clk);
    end
    assertCount++;
    if (!got) begin
      failCount++;
      $display("[TB] FAIL grant timeout: %s ready stayed 0, expected 1", isIf ? "if" : "ls");
    end
    @(negedge clk);
    if (isIf) if_valid = 1'b0;
    else      ls_valid = 1'b0;
  endtask

  task automatic driveReq(input txn_t t);
    if (t.isIf) begin
      if_valid = 1'b1;
      if_addr  = t.addr;
    end else begin
      ls_valid = 1'b1;
      ls_we    = t.write;
      ls_addr  = t.addr;
      ls_size  = t.size;
      ls_wdata = t.wdata;
      ls_wstrb = t.wstrb;
    end
  endtask

  task automatic applyStimulus(input txn_t t);
    reqQ.push_back(t);
    predict(t);
    @(negedge clk);
    driveReq(t);
    waitGrant(t.isIf);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (expQ.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d completions outstanding, expected 0", expQ.size());
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic txn_t mkTxn(input bit isIf, input bit write, input logic [63:0] addr,
                                 input logic [63:0] rdata);
    txn_t t;
    t.write = write;   t.isIf = isIf;   t.addr = addr;
    t.size = isIf ? 3'd2 : 3'd3;
    t.wdata = '0;      t.wstrb = '0;
    t.arDelay = 0;     t.awDelay = 0;   t.wDelay = 0;
    t.rdata = rdata;   t.resp = 2'b00;  t.rid = isIf ? 4'd0 : 4'd1;
    t.rlast = 1'b1;
    return t;
  endfunction

  task automatic slaveRead(input txn_t t);
    checkOutput("ARID", ARID, t.isIf ? 4'd0 : 4'd1);
    checkOutput("ARADDR", ARADDR, t.addr);
    checkOutput("ARSIZE", ARSIZE, t.isIf ? 3'd2 : t.size);
    checkOutput("ARPROT", ARPROT, t.isIf ? 3'b100 : 3'b000);
    checkOutput("ARLEN/ARBURST", {ARLEN, ARBURST}, {8'd0, 2'b01});
    checkOutput("AR tie-offs", {ARLOCK, ARCACHE, ARQOS, ARREGION}, 0);
    for (int i = 0; i < t.arDelay; i++) begin
      @(negedge clk);
      checkOutput("ARVALID hold", ARVALID, 1);
      checkOutput("ARADDR hold", ARADDR, t.addr);
    end
    ARREADY = 1'b1;
    @(negedge clk);
    ARREADY = 1'b0;
    checkOutput("ARVALID after handshake", ARVALID, 0);
    checkOutput("RREADY in R", RREADY, 1);
    RVALID = 1'b1; RDATA = t.rdata; RRESP = t.resp; RID = t.rid; RLAST = t.rlast;
    @(negedge clk);
    RVALID = 1'b0;
    checkOutput("RREADY after beat", RREADY, 0);
  endtask

  task automatic slaveWrite(input txn_t t);
    int maxD = (t.awDelay > t.wDelay) ? t.awDelay : t.wDelay;
    checkOutput("AWID", AWID, 4'd1);
    checkOutput("AWADDR", AWADDR, t.addr);
    checkOutput("AWSIZE", AWSIZE, t.size);
    checkOutput("AWPROT/AWLEN/AWBURST", {AWPROT, AWLEN, AWBURST}, {3'b000, 8'd0, 2'b01});
    checkOutput("AW tie-offs", {AWLOCK, AWCACHE, AWQOS, AWREGION}, 0);
    checkOutput("WDATA", WDATA, t.wdata);
    checkOutput("WSTRB/WLAST", {WSTRB, WLAST}, {t.wstrb, 1'b1});
    for (int k = 0; k <= maxD; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("AWVALID", AWVALID, (k <= t.awDelay) ? 1 : 0);
      checkOutput("WVALID", WVALID, (k <= t.wDelay) ? 1 : 0);
      AWREADY = (k == t.awDelay);
      WREADY  = (k == t.wDelay);
    end
    @(negedge clk);
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    checkOutput("AW/W idle in B", {AWVALID, WVALID}, 0);
    checkOutput("BREADY in B", BREADY, 1);
    BVALID = 1'b1; BRESP = t.resp; BID = t.rid;
    @(negedge clk);
    BVALID = 1'b0;
  endtask

  // Reactive slave: one transaction at a time, fields checked against the issue queue.
  initial begin
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0; RID = '0; RLAST = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0; BID = '0;
    forever begin
      @(negedge clk);
      if (!rstn || manualSlave) continue;
      if (ARVALID || AWVALID || WVALID) begin
        if (reqQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected request: ARVALID=%0b AWVALID=%0b, expected none",
                   ARVALID, AWVALID);
        end else begin
          st = reqQ.pop_front();
          checkOutput("request direction", {ARVALID, AWVALID}, st.write ? 2'b01 : 2'b10);
          if (st.write) slaveWrite(st);
          else          slaveRead(st);
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && (if_rvalid || ls_rvalid)) begin
        checkOutput("single completion", {63'd0, if_rvalid & ls_rvalid}, 0);
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL completion: if_rvalid=%0b ls_rvalid=%0b, expected none",
                   if_rvalid, ls_rvalid);
        end else begin
          me = expQ.pop_front();
          checkOutput("completion port", if_rvalid, me.isIf);
          if (if_rvalid) begin
            checkOutput("if_rdata", if_rdata, me.data);
            checkOutput("if_err", if_err, me.err);
            if (tputMode) begin
              if (lastIfCyc >= 0) checkOutput("fetch interval", 64'(cyc - lastIfCyc), 64'd4);
              lastIfCyc = cyc;
              tputSeen++;
            end
          end else begin
            checkOutput("ls_rdata", ls_rdata, me.data);
            checkOutput("ls_err", ls_err, me.err);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t t, t2;
    int   accepted;

    repeat (3) @(negedge clk);
    checkOutput("reset valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 0);
    checkOutput("reset responses", {if_ready, ls_ready, if_rvalid, ls_rvalid, if_err, ls_err}, 0);
    checkOutput("reset if_rdata", if_rdata, 0);
    checkOutput("reset ls_rdata", ls_rdata, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] directed fetch");
    t = mkTxn(1, 0, 64'h8000_0004, 64'hDEADBEEF_00000013);
    t.arDelay = 2;
    applyStimulus(t);
    waitIdle();

    $display("[TB] simultaneous ls load and fetch");
    t  = mkTxn(0, 0, 64'h8000_1000, 64'h0102030405060708);
    t2 = mkTxn(1, 0, 64'h8000_0000, 64'hCAFEF00D_12345678);
    reqQ.push_back(t);  predict(t);
    reqQ.push_back(t2); predict(t2);
    @(negedge clk);
    driveReq(t);
    driveReq(t2);
    waitGrant(0);
    waitGrant(1);
    waitIdle();

    $display("[TB] store with W before AW");
    t = mkTxn(0, 1, 64'h8000_2000, '0);
    t.wdata = 64'h11223344_55667788;
    t.wstrb = 8'h0F;
    t.wDelay = 0;
    t.awDelay = 3;
    applyStimulus(t);
    waitIdle();

    $display("[TB] load error responses");
    t = mkTxn(0, 0, 64'h8000_3000, 64'hAAAA5555AAAA5555);
    t.resp = 2'b10;
    applyStimulus(t);
    waitIdle();
    t = mkTxn(0, 0, 64'h8000_3008, 64'h0F0F0F0F0F0F0F0F);
    t.rid = 4'd3;
    applyStimulus(t);
    waitIdle();

    $display("[TB] reset while in R");
    manualSlave = 1'b1;
    @(negedge clk);
    if_valid = 1'b1;
    if_addr = 64'h8000_0100;
    waitGrant(1);
    for (int i = 0; i < 20 && !ARVALID; i++) @(negedge clk);
    checkOutput("ARVALID before reset", ARVALID, 1);
    ARREADY = 1'b1;
    @(negedge clk);
    ARREADY = 1'b0;
    checkOutput("RREADY before reset", RREADY, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("async reset valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 0);
    checkOutput("async reset responses", {if_ready, ls_ready, if_rvalid, ls_rvalid, if_err, ls_err}, 0);
    checkOutput("async reset if_rdata", if_rdata, 0);
    checkOutput("async reset ls_rdata", ls_rdata, 0);
    lastLsData = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    manualSlave = 1'b0;
    t = mkTxn(1, 0, 64'h8000_0208, 64'h76543210_89ABCDEF);
    applyStimulus(t);
    waitIdle();

    $display("[TB] back-to-back fetches");
    tputMode = 1'b1;
    lastIfCyc = -1;
    accepted = 0;
    @(negedge clk);
    if_valid = 1'b1;
    if_addr = {$urandom, $urandom} & ~64'h3;
    for (int i = 0; i < 2000 && accepted < 100; i++) begin
      #1;
      if (if_ready) begin
        t = mkTxn(1, 0, if_addr, {$urandom, $urandom});
        reqQ.push_back(t);
        predict(t);
        accepted++;
        @(negedge clk);
        if_addr = {$urandom, $urandom} & ~64'h3;
      end else @(negedge clk);
    end
    if_valid = 1'b0;
    waitIdle();
    checkOutput("fetch completions", tputSeen, 100);
    tputMode = 1'b0;

    $display("[TB] randomized mix");
    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 2);
      t = mkTxn(kind == 0, kind == 2, {$urandom, $urandom}, {$urandom, $urandom});
      if (t.isIf) t.addr[1:0] = 2'b00;
      else begin
        t.size = 3'($urandom_range(0, 3));
        t.addr = t.addr & ~((64'd1 << t.size) - 64'd1);
      end
      t.wdata   = {$urandom, $urandom};
      t.wstrb   = 8'($urandom);
      t.arDelay = $urandom_range(0, 3);
      t.awDelay = $urandom_range(0, 3);
      t.wDelay  = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) t.resp = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) t.rid = 4'($urandom_range(0, 15));
      t.rlast = ($urandom_range(0, 7) != 0);
      applyStimulus(t);
    end
    waitIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
